// File: rtl/control_loop_pi_multichan_if.sv
// rtl/control_loop_pi_multichan_if.sv - request/result bundle for the multichannel PI engine
// CONTROL_LOOP_PI_SAT_FLAG_EN adds the sat and sat_sticky result flags.
interface control_loop_pi_multichan_if #(
   parameter int CHAN_WID        = 2,
   parameter int ADC_WID         = 18,
   parameter int CONSTS_WID      = 48,
   parameter int CYCLE_COUNT_WID = 18,
   parameter int DAC_DATA_WID    = 20
);
   localparam int ERR_WID = ADC_WID + 1;

   logic                              arm;
   logic                              clr;
   logic        [CHAN_WID-1:0]        chan;
   logic signed [ADC_WID-1:0]         setpt;
   logic signed [ADC_WID-1:0]         measured;
   logic signed [CONSTS_WID-1:0]      cl_P;
   logic signed [CONSTS_WID-1:0]      cl_I;
   logic        [CYCLE_COUNT_WID-1:0] cycles;
   logic                              finished;
   logic        [CHAN_WID-1:0]        chan_out;
   logic signed [ERR_WID-1:0]         e_cur;
   logic signed [DAC_DATA_WID-1:0]    adjval;
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
   logic                              sat;
   logic                              sat_sticky;
`endif

   modport master (
      output arm, clr, chan, setpt, measured, cl_P, cl_I, cycles,
      input  finished, chan_out, e_cur, adjval
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
      , sat, sat_sticky
`endif
   );

   modport slave (
      input  arm, clr, chan, setpt, measured, cl_P, cl_I, cycles,
      output finished, chan_out, e_cur, adjval
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
      , sat, sat_sticky
`endif
   );
endinterface

// File: rtl/control_loop_pi_multichan.sv
// rtl/control_loop_pi_multichan.sv - time-multiplexed velocity-form PI engine, one shared shift-add multiplier
// CONTROL_LOOP_PI_SAT_FLAG_EN adds sat/sat_sticky outputs reporting DAC clamping.
module control_loop_pi_multichan #(
   parameter int              CONSTS_WHOLE    = 8,
   parameter int              CONSTS_FRAC     = 40,
   parameter int              ADC_WID         = 18,
   parameter int              DAC_DATA_WID    = 20,
   parameter int              CYCLE_COUNT_WID = 18,
   parameter longint unsigned SEC_PER_CYCLE   = 10995,
   parameter int              NCHAN           = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   control_loop_pi_multichan_if.slave    bus
);
   localparam int CONSTS_WID = CONSTS_WHOLE + CONSTS_FRAC;
   localparam int ERR_WID    = ADC_WID + 1;
   localparam int CHAN_WID   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam int PW         = 2 * CONSTS_WID;
   localparam int SW         = PW + 2;
   localparam int CNT_W      = $clog2(CONSTS_WID + 1);

   localparam logic signed [CONSTS_WID-1:0] SPC = CONSTS_WID'(SEC_PER_CYCLE);
   localparam logic        [CNT_W-1:0]      LAST = CNT_W'(CONSTS_WID);
   localparam logic signed [PW:0] SAT_HI = {{(PW-CONSTS_WID+2){1'b0}}, {(CONSTS_WID-1){1'b1}}};
   localparam logic signed [PW:0] SAT_LO = {{(PW-CONSTS_WID+2){1'b1}}, {(CONSTS_WID-1){1'b0}}};
   localparam logic signed [SW-1:0] DAC_HI = {{(SW-DAC_DATA_WID+1){1'b0}}, {(DAC_DATA_WID-1){1'b1}}};
   localparam logic signed [SW-1:0] DAC_LO = {{(SW-DAC_DATA_WID+1){1'b1}}, {(DAC_DATA_WID-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, MUL_DT, MUL_IDT, MUL_A, MUL_B, ACCUM, DONE} state_t;

   function automatic logic signed [CONSTS_WID-1:0] sat_w(input logic signed [PW:0] v);
      if (v > SAT_HI)      return SAT_HI[CONSTS_WID-1:0];
      else if (v < SAT_LO) return SAT_LO[CONSTS_WID-1:0];
      else                 return v[CONSTS_WID-1:0];
   endfunction

   state_t                       state;
   logic        [CHAN_WID-1:0]   chan_q;
   logic signed [ERR_WID-1:0]    e_q;
   logic signed [CONSTS_WID-1:0] p_q, i_q, dt_q, k_q;
   logic [CYCLE_COUNT_WID-1:0]   cyc_q;
   logic signed [PW-1:0]         a_q, b_q;
   logic signed [PW-1:0]         mul_acc, mul_mcand;
   logic        [CONSTS_WID-1:0] mul_mplier;
   logic        [CNT_W-1:0]      mul_cnt;
   logic signed [ERR_WID-1:0]      e_prev   [NCHAN];
   logic signed [DAC_DATA_WID-1:0] adj_prev [NCHAN];
   logic                         fin_q;
   logic        [CHAN_WID-1:0]   chan_out_q;
   logic signed [ERR_WID-1:0]    e_cur_q;
   logic signed [DAC_DATA_WID-1:0] adj_q;
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
   logic                         sat_q, sticky_q;
`endif

   logic [31:0]                  chan_ext;
   logic                         chan_ok;
   logic signed [ERR_WID-1:0]    e_prev_sel;
   logic signed [DAC_DATA_WID-1:0] adj_prev_sel;
   logic signed [CONSTS_WID-1:0] op_a, op_b;
   logic signed [PW-1:0]         mul_term, mul_next;
   logic signed [SW-1:0]         acc_sum;
   logic signed [DAC_DATA_WID-1:0] acc_clamped;
   logic                         acc_clip;

   // Out-of-range channels run against zero history and never write back.
   assign chan_ext     = 32'(chan_q);
   assign chan_ok      = (chan_ext < 32'(NCHAN));
   assign e_prev_sel   = chan_ok ? e_prev[chan_q]   : '0;
   assign adj_prev_sel = chan_ok ? adj_prev[chan_q] : '0;

   always_comb begin
      op_a = '0;
      op_b = '0;
      case (state)
         MUL_DT:  begin op_a = CONSTS_WID'(cyc_q); op_b = SPC;                     end
         MUL_IDT: begin op_a = i_q;                op_b = dt_q;                    end
         MUL_A:   begin op_a = k_q;                op_b = CONSTS_WID'(e_q);        end
         MUL_B:   begin op_a = p_q;                op_b = CONSTS_WID'(e_prev_sel); end
         default: begin op_a = '0;                 op_b = '0;                      end
      endcase
   end

   // Multiplier sign bit is consumed last and carries negative weight.
   always_comb begin
      mul_term = mul_mplier[0] ? mul_mcand : '0;
      mul_next = (mul_cnt == LAST) ? (mul_acc - mul_term) : (mul_acc + mul_term);
   end

   always_comb begin
      acc_sum     = SW'(adj_prev_sel) + SW'(a_q) - SW'(b_q);
      acc_clip    = 1'b0;
      acc_clamped = acc_sum[DAC_DATA_WID-1:0];
      if (acc_sum > DAC_HI) begin
         acc_clamped = DAC_HI[DAC_DATA_WID-1:0];
         acc_clip    = 1'b1;
      end else if (acc_sum < DAC_LO) begin
         acc_clamped = DAC_LO[DAC_DATA_WID-1:0];
         acc_clip    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         chan_q     <= '0;
         e_q        <= '0;
         p_q        <= '0;
         i_q        <= '0;
         dt_q       <= '0;
         k_q        <= '0;
         cyc_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
         mul_cnt    <= '0;
         fin_q      <= 1'b0;
         chan_out_q <= '0;
         e_cur_q    <= '0;
         adj_q      <= '0;
         for (int c = 0; c < NCHAN; c++) begin
            e_prev[c]   <= '0;
            adj_prev[c] <= '0;
         end
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
         sat_q    <= 1'b0;
         sticky_q <= 1'b0;
`endif
      end else if (state != IDLE && !bus.arm) begin
         state   <= IDLE;
         fin_q   <= 1'b0;
         mul_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.arm) begin
                  chan_q  <= bus.chan;
                  e_q     <= ERR_WID'(bus.setpt) - ERR_WID'(bus.measured);
                  p_q     <= bus.cl_P;
                  i_q     <= bus.cl_I;
                  cyc_q   <= bus.cycles;
                  mul_cnt <= '0;
                  state   <= MUL_DT;
               end else if (bus.clr) begin
                  for (int c = 0; c < NCHAN; c++) begin
                     e_prev[c]   <= '0;
                     adj_prev[c] <= '0;
                  end
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
                  sticky_q <= 1'b0;
`endif
               end
            end
            MUL_DT, MUL_IDT, MUL_A, MUL_B: begin
               if (mul_cnt == '0) begin
                  mul_acc    <= '0;
                  mul_mcand  <= PW'(op_a);
                  mul_mplier <= op_b;
                  mul_cnt    <= CNT_W'(1);
               end else begin
                  mul_acc    <= mul_next;
                  mul_mcand  <= mul_mcand <<< 1;
                  mul_mplier <= mul_mplier >> 1;
                  if (mul_cnt == LAST) begin
                     mul_cnt <= '0;
                     case (state)
                        MUL_DT: begin
                           dt_q  <= sat_w((PW+1)'(mul_next));
                           state <= MUL_IDT;
                        end
                        MUL_IDT: begin
                           k_q   <= sat_w((PW+1)'(p_q) + (PW+1)'(sat_w((PW+1)'(mul_next >>> CONSTS_FRAC))));
                           state <= MUL_A;
                        end
                        MUL_A: begin
                           a_q   <= mul_next >>> CONSTS_FRAC;
                           state <= MUL_B;
                        end
                        default: begin
                           b_q   <= mul_next >>> CONSTS_FRAC;
                           state <= ACCUM;
                        end
                     endcase
                  end else begin
                     mul_cnt <= mul_cnt + 1'b1;
                  end
               end
            end
            ACCUM: begin
               adj_q      <= acc_clamped;
               e_cur_q    <= e_q;
               chan_out_q <= chan_q;
               if (chan_ok) begin
                  e_prev[chan_q]   <= e_q;
                  adj_prev[chan_q] <= acc_clamped;
               end
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
               sat_q    <= acc_clip;
               sticky_q <= sticky_q | acc_clip;
`endif
               state <= DONE;
            end
            DONE: fin_q <= 1'b1;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.finished = fin_q;
   assign bus.chan_out = chan_out_q;
   assign bus.e_cur    = e_cur_q;
   assign bus.adjval   = adj_q;
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
   assign bus.sat        = sat_q;
   assign bus.sat_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_control_loop_pi_multichan.sv
// tb/tb_control_loop_pi_multichan.sv - directed self-checking bench for control_loop_pi_multichan
module tb_control_loop_pi_multichan;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   lat;
   logic seen_fin;
   longint one_q;

   always #5 clk = ~clk;

   control_loop_pi_multichan_if bus ();

   control_loop_pi_multichan dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int ch, input int sp, input int ms, input longint p, input longint i, input int cyc);
      bus.chan     = ch[1:0];
      bus.setpt    = sp[17:0];
      bus.measured = ms[17:0];
      bus.cl_P     = p[47:0];
      bus.cl_I     = i[47:0];
      bus.cycles   = cyc[17:0];
   endtask

   task automatic run(input int ch, input int sp, input int ms, input longint p, input longint i, input int cyc, output int n);
      @(negedge clk);
      drive(ch, sp, ms, p, i, cyc);
      bus.arm = 1'b1;
      @(posedge clk);
      n = 0;
      while (n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.finished) break;
      end
      @(negedge clk);
      bus.arm = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      one_q = 64'sd1 <<< 40;
      rst = 1'b1;
      bus.arm = 1'b0;
      bus.clr = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_finished", longint'(bus.finished), 0);
      check("reset_adjval",   longint'(bus.adjval),   0);
      check("reset_e_cur",    longint'(bus.e_cur),    0);
      check("reset_chan_out", longint'(bus.chan_out), 0);

      run(0, 100, 0, one_q, 0, 1000, lat);
      check("t1_latency",  longint'(lat),          198);
      check("t1_adjval",   longint'(bus.adjval),   100);
      check("t1_e_cur",    longint'(bus.e_cur),    100);
      check("t1_chan_out", longint'(bus.chan_out), 0);
      check("t1_fin_drop", longint'(bus.finished), 0);
      run(0, 100, 0, one_q, 0, 1000, lat);
      check("t1_repeat_adjval", longint'(bus.adjval), 100);

      run(2, 131071, -131072, 100 * one_q, 0, 1000, lat);
      check("t2_e_cur",    longint'(bus.e_cur),    262143);
      check("t2_adjval",   longint'(bus.adjval),   524287);
      check("t2_chan_out", longint'(bus.chan_out), 2);
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
      check("t2_sat", longint'(bus.sat), 1);
`endif

      run(3, 1000, 0, 0, 100 * one_q, 100000, lat);
      check("t3_adjval", longint'(bus.adjval), 99);
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
      check("t3_sat",    longint'(bus.sat),        0);
      check("t3_sticky", longint'(bus.sat_sticky), 1);
`endif

      @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
`ifdef CONTROL_LOOP_PI_SAT_FLAG_EN
      check("clr_sticky", longint'(bus.sat_sticky), 0);
`endif

      run(1, 100, 0, one_q, 0, 1000, lat);
      check("t4_chan1_adjval", longint'(bus.adjval), 100);
      run(0, 100, 0, 0, 0, 1000, lat);
      check("t4_chan0_adjval", longint'(bus.adjval), 0);
      run(1, 0, 0, 0, 0, 1000, lat);
      check("t4_chan1_kept",   longint'(bus.adjval), 100);
      check("t4_chan1_e_cur",  longint'(bus.e_cur),  0);

      @(negedge clk);
      drive(1, 500, 0, one_q, 0, 1000);
      bus.arm = 1'b1;
      repeat (50) @(posedge clk);
      @(negedge clk);
      bus.arm = 1'b0;
      seen_fin = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         seen_fin = seen_fin | bus.finished;
      end
      check("t5_abort_no_fin", longint'(seen_fin),   0);
      check("t5_abort_adjval", longint'(bus.adjval), 100);
      check("t5_abort_e_cur",  longint'(bus.e_cur),  0);
      run(1, 0, 0, 0, 0, 1000, lat);
      check("t5_abort_state", longint'(bus.adjval), 100);

      @(negedge clk);
      drive(1, 300, 0, one_q, 0, 1000);
      bus.arm = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t5_rst_finished", longint'(bus.finished), 0);
      check("t5_rst_adjval",   longint'(bus.adjval),   0);
      check("t5_rst_e_cur",    longint'(bus.e_cur),    0);
      check("t5_rst_chan_out", longint'(bus.chan_out), 0);
      bus.arm = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run(1, 0, 0, 0, 0, 1000, lat);
      check("t5_rst_latency",    longint'(lat),        198);
      check("t5_rst_chan1_zero", longint'(bus.adjval), 0);

      run(0, 100, 0, one_q, 0, 1000, lat);
      check("t5_pre_clr_adjval", longint'(bus.adjval), 100);
      @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      run(0, 100, 0, 0, 0, 1000, lat);
      check("t5_post_clr_adjval", longint'(bus.adjval), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
